// File: rtl/wb_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default data / register-address widths
//   - grant encoding used by the arbitration logic
// ----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_PIPE = 2'b01,
        GNT_MC   = 2'b10
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_sync_fifo.sv
// ----------------------------------------------------------------------------
// wb_sync_fifo
// Small synchronous FIFO buffering multi-cycle unit results.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write request, ignored while full (no write-through)
//   i_pop      : read request, ignored while empty
//   i_wdata    : write data
//   o_rdata    : head entry (valid while !o_empty)
//   o_full     : FIFO holds DEPTH entries
//   o_empty    : FIFO holds no entries
//   o_count    : current occupancy
// DEPTH must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module wb_sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Push is qualified by full only; a same-cycle pop does not free a slot.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed behind r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a buffered multi-cycle (mul/div) result stream. The pipeline
// has priority; a starvation counter forces the FIFO head after the FIFO has
// lost STARVE_LIMIT consecutive arbitrations.
//   clk, rst                         : clock, asynchronous active-high reset
//   pipe_wb_valid/_rd/_data          : pipeline writeback request
//   pipe_stall                       : pipeline request not granted this cycle
//   mc_valid/mc_rd/mc_data, mc_ready : multi-cycle result push handshake
//   rf_we/rf_waddr/rf_wdata          : registered register-file write port
//   mc_pending, mc_count             : FIFO non-empty / occupancy
// Writes to rd==0 are granted and consumed but never drive rf_we.
// ----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned RA_W         = RA_W_DEF,
    parameter int unsigned MC_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_wb_valid,
    input  logic [RA_W-1:0]             pipe_wb_rd,
    input  logic [XLEN-1:0]             pipe_wb_data,
    output logic                        pipe_stall,
    input  logic                        mc_valid,
    output logic                        mc_ready,
    input  logic [RA_W-1:0]             mc_rd,
    input  logic [XLEN-1:0]             mc_data,
    output logic                        rf_we,
    output logic [RA_W-1:0]             rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        mc_pending,
    output logic [$clog2(MC_DEPTH):0]   mc_count
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned EW = RA_W + XLEN;

    logic [EW-1:0]   w_head;
    logic [RA_W-1:0] w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic            w_full;
    logic            w_empty;
    logic            w_force;
    grant_e          w_grant;
    logic [RA_W-1:0] w_sel_rd;
    logic [XLEN-1:0] w_sel_data;

    logic [SW-1:0]   r_starve;

    wb_sync_fifo #(
        .DEPTH (MC_DEPTH),
        .WIDTH (EW)
    ) u_mc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (mc_valid),
        .i_pop   (w_grant == GNT_MC),
        .i_wdata ({mc_rd, mc_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (mc_count)
    );

    assign w_head_rd   = w_head[EW-1:XLEN];
    assign w_head_data = w_head[XLEN-1:0];

    assign mc_ready   = !w_full;
    assign mc_pending = !w_empty;

    assign w_force    = !w_empty && (r_starve == SW'(STARVE_LIMIT));
    assign pipe_stall = w_force && pipe_wb_valid;

    always_comb begin
        w_grant = GNT_NONE;
        if (w_force) begin
            w_grant = GNT_MC;
        end else if (pipe_wb_valid) begin
            w_grant = GNT_PIPE;
        end else if (!w_empty) begin
            w_grant = GNT_MC;
        end
    end

    always_comb begin
        w_sel_rd   = pipe_wb_rd;
        w_sel_data = pipe_wb_data;
        if (w_grant == GNT_MC) begin
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // Counter only advances while the FIFO waits behind the pipeline.
            if (w_empty || w_grant == GNT_MC) begin
                r_starve <= '0;
            end else if (w_grant == GNT_PIPE && r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end

            rf_we <= 1'b0;
            if (w_grant != GNT_NONE && w_sel_rd != '0) begin
                rf_we    <= 1'b1;
                rf_waddr <= w_sel_rd;
                rf_wdata <= w_sel_data;
            end
        end
    end

endmodule
